// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: scoreboard of in-flight destinations
// (EX/MEM/WB), load-use / RAW stall, branch flush and memory freeze.
// Ports: clk, rst (sync, active-high); ID_* decode-side fields;
// EX_branch_taken, MEM_busy; stall/flush controls; stall_cnt,
// flush_cnt saturating counters (CNT_W bits).
// Option: define HAZARD_FORWARD_EN to check only EX-slot loads.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ID_inst,
  input  logic             ID_useA,
  input  logic             ID_useB,
  input  logic             ID_RegWrite,
  input  logic [1:0]       ID_DataToReg,
  input  logic [1:0]       ID_RegDst,
  input  logic             EX_branch_taken,
  input  logic             MEM_busy,
  output logic             PC_stall,
  output logic             IfId_stall,
  output logic             IfId_flush,
  output logic             IdEx_stall,
  output logic             IdEx_flush,
  output logic             ExMem_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] a;
    logic       ld;
  } slot_t;

  slot_t sb_ex;
  slot_t sb_mem;
  slot_t sb_wb;

  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] dst;
  logic       dst_v;
  slot_t      id_slot;

  assign rs = ID_inst[25:21];
  assign rt = ID_inst[20:16];
  assign rd = ID_inst[15:11];

  always_comb begin
    dst   = 5'd0;
    dst_v = 1'b0;
    unique case (ID_RegDst)
      2'b00:   dst = rt;
      2'b01:   dst = rd;
      2'b10:   dst = 5'd31;
      default: dst = 5'd0;
    endcase
    // $0 is never a real producer
    dst_v = ID_RegWrite
         && (ID_RegDst != 2'b11)
         && (dst != 5'd0);
  end

  assign id_slot.v  = dst_v;
  assign id_slot.a  = dst;
  assign id_slot.ld = (ID_DataToReg == 2'b01);

  function automatic logic hit(input slot_t s);
    hit = s.v
       && ((ID_useA && (rs == s.a))
        || (ID_useB && (rt == s.a)));
  endfunction

  logic haz;

`ifdef HAZARD_FORWARD_EN
  // MEM/WB results reach EX through the bypass
  assign haz = hit(sb_ex) && sb_ex.ld;
`else
  // no bypass and no write-through: WB match still stalls
  assign haz = hit(sb_ex)
            || hit(sb_mem)
            || hit(sb_wb);
`endif

  logic frz;
  logic brn;
  logic stl;

  assign frz = MEM_busy;
  assign brn = !MEM_busy && EX_branch_taken;
  assign stl = !MEM_busy && !EX_branch_taken && haz;

  always_comb begin
    PC_stall    = 1'b0;
    IfId_stall  = 1'b0;
    IfId_flush  = 1'b0;
    IdEx_stall  = 1'b0;
    IdEx_flush  = 1'b0;
    ExMem_stall = 1'b0;
    unique case (1'b1)
      frz: begin
        PC_stall    = 1'b1;
        IfId_stall  = 1'b1;
        IdEx_stall  = 1'b1;
        ExMem_stall = 1'b1;
      end
      brn: begin
        IfId_flush = 1'b1;
        IdEx_flush = 1'b1;
      end
      stl: begin
        PC_stall   = 1'b1;
        IfId_stall = 1'b1;
        IdEx_flush = 1'b1;
      end
      default: ;
    endcase
  end

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_ex     <= '0;
      sb_mem    <= '0;
      sb_wb     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (1'b1)
        frz: ;
        brn: begin
          sb_ex  <= '0;
          sb_mem <= sb_ex;
          sb_wb  <= sb_mem;
          if (flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_ONE;
        end
        stl: begin
          sb_ex  <= '0;
          sb_mem <= sb_ex;
          sb_wb  <= sb_mem;
          if (stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_ONE;
        end
        default: begin
          sb_ex  <= id_slot;
          sb_mem <= sb_ex;
          sb_wb  <= sb_mem;
        end
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ID_inst[31:26], ID_inst[10:0], sb_wb};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus
// randomized traffic against an in-flight instruction list model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ID_inst;
  logic        ID_useA, ID_useB, ID_RegWrite;
  logic [1:0]  ID_DataToReg, ID_RegDst;
  logic        EX_branch_taken, MEM_busy;

  logic        PC_stall, IfId_stall, IfId_flush;
  logic        IdEx_stall, IdEx_flush, ExMem_stall;
  logic [15:0] stall_cnt, flush_cnt;

  logic        PC_stall2, IfId_stall2, IfId_flush2;
  logic        IdEx_stall2, IdEx_flush2, ExMem_stall2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ID_inst(ID_inst),
    .ID_useA(ID_useA), .ID_useB(ID_useB),
    .ID_RegWrite(ID_RegWrite), .ID_DataToReg(ID_DataToReg),
    .ID_RegDst(ID_RegDst), .EX_branch_taken(EX_branch_taken),
    .MEM_busy(MEM_busy), .PC_stall(PC_stall),
    .IfId_stall(IfId_stall), .IfId_flush(IfId_flush),
    .IdEx_stall(IdEx_stall), .IdEx_flush(IdEx_flush),
    .ExMem_stall(ExMem_stall), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .ID_inst(ID_inst),
    .ID_useA(ID_useA), .ID_useB(ID_useB),
    .ID_RegWrite(ID_RegWrite), .ID_DataToReg(ID_DataToReg),
    .ID_RegDst(ID_RegDst), .EX_branch_taken(EX_branch_taken),
    .MEM_busy(MEM_busy), .PC_stall(PC_stall2),
    .IfId_stall(IfId_stall2), .IfId_flush(IfId_flush2),
    .IdEx_stall(IdEx_stall2), .IdEx_flush(IdEx_flush2),
    .ExMem_stall(ExMem_stall2), .stall_cnt(stall_cnt2),
    .flush_cnt(flush_cnt2)
  );

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // model: in-flight producers, index 0 = youngest (EX stage)
  int  m_dst[3];
  bit  m_ld[3];
  int  m_sc, m_fc;

  // expected controls of the current cycle
  bit  e_pc, e_ifs, e_iff, e_ies, e_ief, e_ems;
  bit  last_stall;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int s, input int t,
                                     input int d);
    logic [31:0] w;
    w = 32'h0;
    w[25:21] = 5'(s);
    w[20:16] = 5'(t);
    w[15:11] = 5'(d);
    return w;
  endfunction

  // destination written by the decode instruction, 0 if none
  function automatic int id_dest();
    int d;
    if (!ID_RegWrite) return 0;
    case (ID_RegDst)
      2'b00: d = int'(ID_inst[20:16]);
      2'b01: d = int'(ID_inst[15:11]);
      2'b10: d = 31;
      default: d = 0;
    endcase
    return d;
  endfunction

  function automatic bit reads(input int r);
    return r != 0 &&
      ((ID_useA && int'(ID_inst[25:21]) == r) ||
       (ID_useB && int'(ID_inst[20:16]) == r));
  endfunction

  function automatic bit model_haz();
    if (FWD) return m_ld[0] && reads(m_dst[0]);
    for (int i = 0; i < 3; i++)
      if (reads(m_dst[i])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_expect();
    bit h;
    h = model_haz();
    {e_pc, e_ifs, e_iff, e_ies, e_ief, e_ems} = '0;
    if (MEM_busy) begin
      e_pc = 1; e_ifs = 1; e_ies = 1; e_ems = 1;
    end else if (EX_branch_taken) begin
      e_iff = 1; e_ief = 1;
    end else if (h) begin
      e_pc = 1; e_ifs = 1; e_ief = 1;
    end
  endtask

  task automatic model_clock(input bit h, input int d,
                             input bit ld);
    if (rst) begin
      m_dst = '{0, 0, 0};
      m_ld  = '{0, 0, 0};
      m_sc = 0; m_fc = 0;
    end else if (!MEM_busy) begin
      m_dst[2] = m_dst[1]; m_ld[2] = m_ld[1];
      m_dst[1] = m_dst[0]; m_ld[1] = m_ld[0];
      if (EX_branch_taken || h) begin
        m_dst[0] = 0; m_ld[0] = 0;
        if (EX_branch_taken) m_fc++;
        else m_sc++;
      end else begin
        m_dst[0] = d; m_ld[0] = ld;
      end
    end
  endtask

  task automatic compare();
    chk("PC_stall", PC_stall, e_pc);
    chk("IfId_stall", IfId_stall, e_ifs);
    chk("IfId_flush", IfId_flush, e_iff);
    chk("IdEx_stall", IdEx_stall, e_ies);
    chk("IdEx_flush", IdEx_flush, e_ief);
    chk("ExMem_stall", ExMem_stall, e_ems);
    chk("stall_cnt", stall_cnt, m_sc > 65535 ? 65535 : m_sc);
    chk("flush_cnt", flush_cnt, m_fc > 65535 ? 65535 : m_fc);
    chk("w2 PC_stall", PC_stall2, e_pc);
    chk("w2 stall_cnt", stall_cnt2, m_sc > 3 ? 3 : m_sc);
    chk("w2 flush_cnt", flush_cnt2, m_fc > 3 ? 3 : m_fc);
  endtask

  task automatic step(input logic [31:0] inst, input bit ua,
                      input bit ub, input bit rw,
                      input logic [1:0] d2r,
                      input logic [1:0] rdst, input bit br,
                      input bit busy, input bit r);
    bit h;
    ID_inst = inst; ID_useA = ua; ID_useB = ub;
    ID_RegWrite = rw; ID_DataToReg = d2r; ID_RegDst = rdst;
    EX_branch_taken = br; MEM_busy = busy; rst = r;
    @(negedge clk);
    if (!rst) begin
      model_expect();
      compare();
    end
    last_stall = PC_stall;
    h = model_haz();
    @(posedge clk);
    model_clock(h, id_dest(), ID_DataToReg == 2'b01);
    #1;
  endtask

  // decode instruction held until stalls clear; returns stall cycles
  task automatic hold(input logic [31:0] inst, input bit ua,
                      input bit ub, output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(inst, ua, ub, 1, 2'b00, 2'b01, 0, 0, 0);
      if (!last_stall) return;
      n++;
    end
    chk("stall bound", n, 0);
  endtask

  int n, s0, f0, tot;

  initial begin
    m_dst = '{0, 0, 0};
    m_ld  = '{0, 0, 0};
    m_sc = 0; m_fc = 0;

    step(32'h0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 1);
    step(32'h0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 1);
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset flush_cnt", flush_cnt, 0);
    chk("reset PC_stall", PC_stall, 0);

    // load-use: lw $8 then add reading rs=8
    s0 = int'(stall_cnt);
    step(mk(0, 8, 0), 1, 0, 1, 2'b01, 2'b00, 0, 0, 0);
    hold(mk(8, 0, 3), 1, 1, n);
    chk("loaduse cycles", n, FWD ? 1 : 3);
    chk("loaduse stall_cnt", int'(stall_cnt) - s0, FWD ? 1 : 3);

    // ALU RAW: add $9 then sub reading rt=9
    s0 = int'(stall_cnt);
    step(mk(1, 2, 9), 1, 1, 1, 2'b00, 2'b01, 0, 0, 0);
    hold(mk(4, 9, 5), 1, 1, n);
    chk("raw cycles", n, FWD ? 0 : 3);
    chk("raw stall_cnt", int'(stall_cnt) - s0, FWD ? 0 : 3);

    // $0 destination never stalls
    step(mk(1, 0, 0), 1, 0, 1, 2'b01, 2'b00, 0, 0, 0);
    hold(mk(0, 6, 7), 1, 1, n);
    chk("zero dst cycles", n, 0);

    // branch in the same cycle as a load-use hazard
    s0 = int'(stall_cnt); f0 = int'(flush_cnt);
    step(mk(0, 10, 0), 1, 0, 1, 2'b01, 2'b00, 0, 0, 0);
    step(mk(10, 0, 3), 1, 0, 1, 2'b00, 2'b01, 1, 0, 0);
    chk("br IfId_flush", IfId_flush, 1);
    chk("br PC_stall", last_stall, 0);
    chk("br flush_cnt", int'(flush_cnt) - f0, 1);
    chk("br stall_cnt", int'(stall_cnt) - s0, 0);

    // memory freeze across a load-use stall
    s0 = int'(stall_cnt);
    step(mk(0, 11, 0), 1, 0, 1, 2'b01, 2'b00, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(mk(11, 0, 3), 1, 0, 1, 2'b00, 2'b01, 0, 1, 0);
      chk("frz ExMem_stall", ExMem_stall, 1);
      chk("frz stall_cnt", int'(stall_cnt), s0);
    end
    hold(mk(11, 0, 3), 1, 0, n);
    chk("frz cycles", n, FWD ? 1 : 3);
    chk("frz stall_cnt end", int'(stall_cnt) - s0, FWD ? 1 : 3);

    // reset in the middle of a stall
    step(mk(0, 12, 0), 1, 0, 1, 2'b01, 2'b00, 0, 0, 0);
    step(mk(12, 0, 3), 1, 0, 1, 2'b00, 2'b01, 0, 0, 0);
    chk("pre-rst stall", last_stall, 1);
    step(mk(12, 0, 3), 1, 0, 1, 2'b00, 2'b01, 0, 0, 1);
    step(mk(12, 0, 3), 1, 0, 1, 2'b00, 2'b01, 0, 0, 0);
    chk("post-rst stall", last_stall, 0);
    chk("post-rst stall_cnt", stall_cnt, 0);
    chk("post-rst flush_cnt", flush_cnt, 0);

    // five load-use pairs: narrow counter saturates at 3
    tot = 0;
    for (int k = 0; k < 5; k++) begin
      step(mk(0, 13 + k, 0), 1, 0, 1, 2'b01, 2'b00, 0, 0, 0);
      hold(mk(13 + k, 0, 3), 1, 0, n);
      tot += n;
    end
    chk("sat wide", stall_cnt, tot);
    chk("sat narrow", stall_cnt2, 3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] w;
      bit r, b, bz;
      w  = $urandom;
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
      w[15:11] = 5'($urandom_range(0, 3));
      r  = ($urandom_range(0, 99) == 0);
      bz = !r && ($urandom_range(0, 7) == 0);
      b  = !r && ($urandom_range(0, 9) == 0);
      step(w, 1'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), 2'($urandom), b, bz, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
